// File: rtl/vga_pkg.sv
//==============================================================================
// Module      : vga_pkg
// Description : Shared 800x600 timing constants, pixel types and the image
//               defaults used by the draw stages.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  typedef logic [11:0] rgb_t;

  localparam int   IMG_W_DEF   = 64;
  localparam int   IMG_H_DEF   = 64;
  localparam rgb_t BG_RGB_DEF  = 12'h1_3_5;
  localparam rgb_t KEY_RGB_DEF = 12'hF_0_F;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
  } vga_timing_t;

  // Half-open interval test done 13 bits wide so start+len can never wrap.
  function automatic logic in_span(input logic [12:0] pos,
                                   input logic [12:0] start,
                                   input logic [12:0] len);
    return (pos >= start) && (pos < (start + len));
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
//==============================================================================
// Module      : vga_if
// Description : VGA timing bundle plus pixel colour passed between stages.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (
    output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

  modport in (
    input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

  modport master (
    output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

  modport slave (
    input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

endinterface

`default_nettype wire

// File: rtl/vga_delay.sv
//==============================================================================
// Module      : vga_delay
// Description : N-stage shift register for the VGA timing fields; every
//               stage is exposed so callers can tap intermediate delays.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_delay
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  vga_timing_t din,
  output vga_timing_t taps [N]
);

  vga_timing_t r_stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < N; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign taps = r_stage;

endmodule

`default_nettype wire

// File: rtl/draw_img.sv
//==============================================================================
// Module      : draw_img
// Description : Overlays an IMG_W x IMG_H ROM image at a per-frame latched
//               position on a flat background; two-cycle pipeline.
//               Build option: define TRANSPARENT_KEY_EN to show the
//               background wherever the ROM returns KEY_RGB.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module draw_img
  import vga_pkg::*;
#(
  parameter int   IMG_W   = IMG_W_DEF,
  parameter int   IMG_H   = IMG_H_DEF,
  parameter rgb_t BG_RGB  = BG_RGB_DEF,
  parameter rgb_t KEY_RGB = KEY_RGB_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] pixel_addr,
  input  rgb_t        rgb_pixel
);

  localparam int          c_COL_W = $clog2(IMG_W);
  localparam int          c_ROW_W = $clog2(IMG_H);
  localparam logic [12:0] c_W13   = 13'(IMG_W);
  localparam logic [12:0] c_H13   = 13'(IMG_H);

  vga_timing_t w_timing;
  vga_timing_t w_taps [2];

  logic        r_vblnk_prev;
  logic [11:0] r_xpos_q;
  logic [11:0] r_ypos_q;
  logic        r_in_rect_d;
  rgb_t        r_rgb;

  logic        w_in_rect;
  logic [12:0] w_col;
  logic [12:0] w_row;
  logic        w_blank_d;
  rgb_t        w_rgb_next;
  logic        w_unused;

  assign w_timing.vcount = vga_in.vcount;
  assign w_timing.hcount = vga_in.hcount;
  assign w_timing.vsync  = vga_in.vsync;
  assign w_timing.hsync  = vga_in.hsync;
  assign w_timing.vblnk  = vga_in.vblnk;
  assign w_timing.hblnk  = vga_in.hblnk;

  vga_delay #(
    .N (2)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (w_timing),
    .taps  (w_taps)
  );

  // Position is captured only at the start of vertical blanking so the
  // sprite cannot move partway through a visible frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_prev <= 1'b0;
      r_xpos_q     <= '0;
      r_ypos_q     <= '0;
    end else begin
      r_vblnk_prev <= vga_in.vblnk;
      if (vga_in.vblnk && !r_vblnk_prev) begin
        r_xpos_q <= xpos;
        r_ypos_q <= ypos;
      end
    end
  end

  assign w_in_rect = in_span({2'b00, vga_in.hcount}, {1'b0, r_xpos_q}, c_W13) &&
                     in_span({2'b00, vga_in.vcount}, {1'b0, r_ypos_q}, c_H13);
  assign w_col     = {2'b00, vga_in.hcount} - {1'b0, r_xpos_q};
  assign w_row     = {2'b00, vga_in.vcount} - {1'b0, r_ypos_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_rect_d <= 1'b0;
      pixel_addr  <= '0;
    end else begin
      r_in_rect_d <= w_in_rect;
      if (w_in_rect) begin
        pixel_addr <= 12'({w_row[c_ROW_W-1:0], w_col[c_COL_W-1:0]});
      end
    end
  end

  // Blanking is taken from the stage-1 copy so it lines up with rgb_pixel.
  assign w_blank_d = w_taps[0].vblnk | w_taps[0].hblnk;

  always_comb begin
    w_rgb_next = BG_RGB;
    if (w_blank_d) begin
      w_rgb_next = '0;
    end else if (r_in_rect_d) begin
`ifdef TRANSPARENT_KEY_EN
      w_rgb_next = (rgb_pixel == KEY_RGB) ? BG_RGB : rgb_pixel;
`else
      w_rgb_next = rgb_pixel;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgb_next;
    end
  end

  assign vga_out.vcount = w_taps[1].vcount;
  assign vga_out.hcount = w_taps[1].hcount;
  assign vga_out.vsync  = w_taps[1].vsync;
  assign vga_out.hsync  = w_taps[1].hsync;
  assign vga_out.vblnk  = w_taps[1].vblnk;
  assign vga_out.hblnk  = w_taps[1].hblnk;
  assign vga_out.rgb    = r_rgb;

`ifdef TRANSPARENT_KEY_EN
  assign w_unused = ^{vga_in.rgb, w_taps[0], w_row[12:c_ROW_W], w_col[12:c_COL_W]};
`else
  assign w_unused = ^{vga_in.rgb, w_taps[0], w_row[12:c_ROW_W], w_col[12:c_COL_W],
                      KEY_RGB};
`endif

endmodule

`default_nettype wire

// File: tb/tb_draw_img.sv
//==============================================================================
// Module      : tb_draw_img
// Description : Directed scoreboard bench for draw_img; the ROM model
//               returns its address as data.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_draw_img;
  import vga_pkg::*;

  localparam rgb_t c_BG  = BG_RGB_DEF;
  localparam rgb_t c_KEY = 12'hF0F;

  typedef struct packed {
    logic [10:0] vc;
    logic [10:0] hc;
    logic        vs;
    logic        hs;
    logic        vb;
    logic        hb;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] pixel_addr;
  rgb_t        rgb_pixel;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  assign rgb_pixel = pixel_addr;

  draw_img dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_in     (vin),
    .vga_out    (vout),
    .xpos       (xpos),
    .ypos       (ypos),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel)
  );

  pix_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   m_xq  = 0;
  int   m_yq  = 0;
  bit   m_prev = 1'b0;

  function automatic pix_t observe();
    pix_t p;
    p.vc  = vout.vcount;
    p.hc  = vout.hcount;
    p.vs  = vout.vsync;
    p.hs  = vout.hsync;
    p.vb  = vout.vblnk;
    p.hb  = vout.hblnk;
    p.rgb = vout.rgb;
    return p;
  endfunction

  task automatic check_pix(input string tag, input pix_t obs, input pix_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, predict its output, advance one clock, retire the
  // prediction whose two-cycle latency has just elapsed.
  task automatic drive(input int h, input int v);
    pix_t e;
    pix_t got;
    bit   inr;
    int   data;
    e.hb = (h >= HOR_PIXELS);
    e.vb = (v >= VER_PIXELS);
    e.hs = (h >= 840) && (h < 968);
    e.vs = (v >= 601) && (v < 605);
    e.hc = 11'(h);
    e.vc = 11'(v);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = e.hs;
    vin.vsync  = e.vs;
    vin.hblnk  = e.hb;
    vin.vblnk  = e.vb;
    vin.rgb    = 12'h000;
    inr = (h >= m_xq) && (h < m_xq + 64) && (v >= m_yq) && (v < m_yq + 64);
    data = (v - m_yq) * 64 + (h - m_xq);
    if (e.hb || e.vb)
      e.rgb = 12'h000;
    else if (inr) begin
      e.rgb = 12'(data);
`ifdef TRANSPARENT_KEY_EN
      if (e.rgb == c_KEY) e.rgb = c_BG;
`endif
    end else
      e.rgb = c_BG;
    sbq.push_back(e);
    if (e.vb && !m_prev) begin
      m_xq = int'(xpos);
      m_yq = int'(ypos);
    end
    m_prev = e.vb;
    @(posedge clk);
    #1;
    if (sbq.size() == 2) begin
      e   = sbq.pop_front();
      got = observe();
      check_pix($sformatf("pipe h=%0d v=%0d", e.hc, e.vc), got, e);
    end
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) drive(h, v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_pix("reset_out", observe(), '0);
    check12("reset_addr", pixel_addr, 12'h000);
    @(posedge clk);
    #1;
    check_pix("reset_hold", observe(), '0);
    rst_n = 1'b1;
    sbq.delete();
    m_xq   = 0;
    m_yq   = 0;
    m_prev = 1'b0;
  endtask

  initial begin
    rgb_t key_exp;
    rst_n      = 1'b1;
    xpos       = 12'd100;
    ypos       = 12'd50;
    vin.hcount = '0;
    vin.vcount = '0;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset mid-line at hcount=300, then position stays 0 until vblank.
    line(10, 290, 299);
    vin.hcount = 11'd300;
    do_reset();
    line(5, 0, 70);

    // Latch (100,50) and probe the image corners and edges.
    line(600, 0, 3);
    line(50, 95, 99);
    drive(100, 50);
    check12("addr_top_left", pixel_addr, 12'h000);
    line(50, 101, 170);
    line(110, 112, 115);
    drive(116, 110);
`ifdef TRANSPARENT_KEY_EN
    key_exp = c_BG;
`else
    key_exp = c_KEY;
`endif
    check12("key_pixel_rgb", vout.rgb, key_exp);
    line(110, 117, 118);
    line(113, 160, 162);
    drive(163, 113);
    check12("addr_bot_right", pixel_addr, 12'hFFF);
    line(113, 164, 166);

    // Mid-frame xpos change only lands at the next vblank rising edge.
    line(100, 98, 102);
    xpos = 12'd400;
    line(110, 98, 102);
    line(110, 398, 402);
    line(600, 0, 2);
    line(60, 398, 402);
    line(60, 98, 102);

    // Right-edge clipping without wrap to column 0.
    xpos = 12'd780;
    ypos = 12'd50;
    line(599, 0, 0);
    line(600, 0, 0);
    line(60, 775, 825);
    line(60, 0, 5);

    // Bottom clipping: blank beats image; sync fields follow exactly.
    xpos = 12'd100;
    ypos = 12'd580;
    line(599, 0, 0);
    line(600, 0, 0);
    line(590, 98, 110);
    line(599, 98, 110);
    line(610, 98, 110);
    line(602, 835, 845);
    line(604, 965, 970);

    // Off-screen position: everything visible is background.
    xpos = 12'd900;
    ypos = 12'd50;
    line(10, 0, 0);
    line(600, 0, 0);
    line(60, 95, 110);
    line(60, 895, 900);

    drive(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/draw_img.md
Name: draw_img

Overview:
- Pixel stage directly downstream of vga_timing.
- Consumes the raw timing bundle and overlays a 64x64 image, read from an external synchronous ROM, at a movable (x, y) position on a flat background colour.
- Emits a timing bundle delayed to match, with rgb filled, for the next draw stage or the VGA output register.
- The position is sampled once per frame, so a sprite never tears mid-frame.

Parameters:
- IMG_W, 64, image width in pixels; power of two.
- IMG_H, 64, image height in pixels; power of two.
- BG_RGB, 12'h1_3_5, background colour for active pixels outside the image.
- KEY_RGB, 12'hF_0_F, transparent colour; used only with TRANSPARENT_KEY_EN.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- vga_in  vga_if.in  -  vcount/hcount (11b), vsync, hsync, vblnk, hblnk from vga_timing; rgb is ignored.
- vga_out  vga_if.out  -  delayed timing plus rgb (12b).
- xpos  in  12  requested image left edge, in pixels.
- ypos  in  12  requested image top edge, in pixels.
- pixel_addr  out  12  ROM address {row[5:0], col[5:0]}.
- rgb_pixel  in  12  ROM data, valid 1 cycle after pixel_addr.

Behaviour:
- Reset (rst_n=0, async) clears every output register immediately and holds it while low:
  - vga_out.vcount/hcount=0; vsync/hsync/vblnk/hblnk=0; rgb=0.
  - pixel_addr=0.
  - Internal xpos_q/ypos_q=0; pipeline valid flags=0.
- Position latch:
  - xpos_q/ypos_q load xpos/ypos on the cycle where vga_in.vblnk=1 and the previous vblnk=0 (rising edge).
  - Otherwise they hold.
  - A change of xpos mid-frame takes effect only in the next frame.
- Stage 1 (cycle n+1):
  - Register all vga_in timing fields.
  - in_rect = (hcount >= xpos_q) && (hcount < xpos_q+IMG_W) && (vcount >= ypos_q) && (vcount < ypos_q+IMG_H).
  - Sums are computed 13b wide; no wrap.
  - pixel_addr <= {vcount-ypos_q, hcount-xpos_q}[low bits] when in_rect, else it holds its last value.
- Stage 2 (cycle n+2):
  - Register the timing fields again.
  - rgb <= 0 if (vblnk|hblnk); else rgb_pixel if in_rect_d; else BG_RGB.
- Latency: exactly 2 cycles from vga_in to vga_out for all fields. Relative alignment of hsync/vsync/blank is preserved bit-exactly.
- Clipping:
  - An image partly beyond 800x600 is drawn only where blank=0.
  - xpos >= 800 or ypos >= 600 means the image is invisible; no error.
- Blank always wins over image/background, even if in_rect.
- Reset deasserted mid-frame: outputs follow vga_in after 2 cycles. Position stays 0 until the next vblnk rising edge.
- No back-pressure; one pixel accepted every clock.

Optional Feature:
- Macro TRANSPARENT_KEY_EN.
- Defined: in stage 2, an in_rect pixel with rgb_pixel==KEY_RGB outputs BG_RGB instead.
- Undefined: KEY_RGB is unused and every in_rect pixel outputs rgb_pixel.
- Latency is unchanged either way.

Decomposition:
- vga_pkg gains typedef rgb_t (logic [11:0]) and constants IMG_W_DEF=64, IMG_H_DEF=64, BG_RGB_DEF, KEY_RGB_DEF.
- Existing HOR_PIXELS=800 / VER_PIXELS=600 are reused.
- One natural sub-module: vga_delay, a parameterised N-stage register of the vga_if timing fields with async active-low reset, used here with N=2.
- The ROM (image_rom, $readmemh) stays outside this block.

Test Plan:
- Reset mid-line (rst_n low at hcount=300): all vga_out fields are 0 within the same cycle. After release, vga_out.hcount equals vga_in.hcount from 2 cycles earlier.
- xpos=100, ypos=50, ROM returns addr as data:
  - At vga_in (hcount=100, vcount=50), pixel_addr=0 one cycle later.
  - At (163, 113), pixel_addr=12'hFFF.
  - rgb at those pixels = ROM data 2 cycles later.
  - (99, 50) and (164, 50) give BG_RGB.
- Position latch: change xpos 100->400 at vcount=300. The rest of the frame still draws at 100; the next frame draws at 400.
- Clipping: xpos=780. Columns 780..799 show the image; hcount 800..819 give rgb=0 (hblnk). Check there is no wrap to column 0.
- Blank priority: ypos=580. Rows 600..643 give rgb=0. sync/blank timing equals vga_in delayed by exactly 2 over a full frame.
- TRANSPARENT_KEY_EN build: ROM returns 12'hF0F at a given image pixel -> rgb=BG_RGB. Without the macro -> rgb=12'hF0F.
